// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port
// indices, default memory size and the latched command layout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int DEF_MEM_WORDS = 256;

    // Command captured at grant time and replayed to memory in ACCESS.
    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // A byte address is rejected when it is not word aligned or its word
    // index falls outside the memory.
    function automatic logic addr_is_bad(input logic [31:0] addr, input logic [31:0] words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= words);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin pick. Purely combinational; the caller owns the
// last-granted pointer and decides whether arbitration is open.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention the port that did not win last time wins now; a lone
    // requester always wins.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt = (last == PORT_LDR) ? 2'b01 : 2'b10;
        else
            gnt = req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) arbiter in front of a single-ported 32-bit memory.
// One transaction every two cycles: grant (IDLE/RESP) -> ACCESS -> RESP(ack).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        gnt0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,

    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    arb_state_t  state, state_nxt;
    logic        last_q;
    cmd_t        cmd_q, cmd_nxt;
    logic        arb_open;
    logic [1:0]  pick;
    logic [1:0]  gnt_v;
    logic        cmd_err;
    logic [31:0] resp_data;

    rr_arb2 u_rr_arb2 (
        .req  ({req1, req0}),
        .last (last_q),
        .gnt  (pick)
    );

    // Arbitration is open in IDLE and RESP, never while reset is held low.
    always_comb begin
        arb_open = reset && ((state == IDLE) || (state == RESP));
        gnt_v    = arb_open ? pick : 2'b00;
    end

    // Select the winning port's command for latching.
    always_comb begin
        cmd_nxt.owner = gnt_v[1];
        cmd_nxt.we    = gnt_v[1] ? we1    : we0;
        cmd_nxt.addr  = gnt_v[1] ? addr1  : addr0;
        cmd_nxt.wdata = gnt_v[1] ? wdata1 : wdata0;
    end

    // Error status and response word for the command now in ACCESS.
    always_comb begin
        cmd_err   = addr_is_bad(cmd_q.addr, 32'(MEM_WORDS));
        resp_data = 32'd0;
        if (!cmd_err && !cmd_q.we)
            resp_data = mem_rdata;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: any grant starts an access; otherwise drop to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: state_nxt = (gnt_v != 2'b00) ? ACCESS : IDLE;
            ACCESS:     state_nxt = RESP;
            default:    state_nxt = IDLE;
        endcase
    end

    // FSM outputs: grants, memory strobes and busy. The write strobe is
    // also gated by reset so an abort in ACCESS never reaches memory.
    always_comb begin
        gnt0      = gnt_v[0];
        gnt1      = gnt_v[1];
        mem_addr  = cmd_q.addr;
        mem_wdata = cmd_q.wdata;
        mem_read  = (state == ACCESS) && !cmd_q.we && !cmd_err;
        mem_write = (state == ACCESS) &&  cmd_q.we && !cmd_err && reset;
        busy      = (state == ACCESS) || (state == RESP);
    end

    // Latch the granted command and remember who won.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_q  <= '0;
            last_q <= PORT_LDR;
        end else if (gnt_v != 2'b00) begin
            cmd_q  <= cmd_nxt;
            last_q <= gnt_v[1];
        end
    end

    // Capture the response at the end of ACCESS so the owner sees a
    // one-cycle ack in RESP; the other port's rdata is left untouched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= 32'd0;
            rdata1 <= 32'd0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (state == ACCESS) begin
                if (cmd_q.owner == PORT_LDR) begin
                    ack1   <= 1'b1;
                    err1   <= cmd_err;
                    rdata1 <= resp_data;
                end else begin
                    ack0   <= 1'b1;
                    err0   <= cmd_err;
                    rdata0 <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected acks, memory
// accesses and point probes; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    localparam int MW = 256;

    localparam int S_GNT0  = 0;
    localparam int S_GNT1  = 1;
    localparam int S_ACK0  = 2;
    localparam int S_ACK1  = 3;
    localparam int S_ERR0  = 4;
    localparam int S_ERR1  = 5;
    localparam int S_RD0   = 6;
    localparam int S_RD1   = 7;
    localparam int S_BUSY  = 8;
    localparam int S_MADDR = 9;
    localparam int S_MWR   = 10;
    localparam int S_MRD   = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;

    typedef struct { int cyc; logic port; logic err; logic [31:0] rdata; } ack_exp_t;
    typedef struct { int cyc; logic wr; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
    typedef struct { int cyc; int sig; logic [31:0] val; string name; } probe_t;

    ack_exp_t    sbq[$];
    mem_exp_t    mq[$];
    probe_t      pq[$];
    logic [31:0] mem [MW];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          stim_to = 0;
    logic        done = 1'b0;

    mem_arbiter #(.MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: preloaded on the first edge, written on mem_write.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < MW; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[4]  <= 32'hDEAD_BEEF;
            mem[5]  <= 32'h55AA_55AA;
            mem[12] <= 32'hCAFE_000C;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_GNT0:  return 32'(gnt0);
            S_GNT1:  return 32'(gnt1);
            S_ACK0:  return 32'(ack0);
            S_ACK1:  return 32'(ack1);
            S_ERR0:  return 32'(err0);
            S_ERR1:  return 32'(err1);
            S_RD0:   return rdata0;
            S_RD1:   return rdata1;
            S_BUSY:  return 32'(busy);
            S_MADDR: return mem_addr;
            S_MWR:   return 32'(mem_write);
            S_MRD:   return 32'(mem_read);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Monitor: invariants every cycle, then scoreboard pops on ack and
    // memory strobes, then due probes; ends the run when stimulus is done.
    always @(negedge clk) begin
        ack_exp_t a;
        mem_exp_t m;
        probe_t   p;
        chk("ack_overlap", 32'(ack0 & ack1), 32'd0);
        chk("strobe_excl", 32'(mem_read & mem_write), 32'd0);
        if (!reset) chk("gnt_in_reset", 32'({gnt1, gnt0}), 32'd0);
        if (ack0 || ack1) begin
            if (sbq.size() == 0) chk("unexpected_ack", 32'({ack1, ack0}), 32'd0);
            else begin
                a = sbq.pop_front();
                chk("ack_port",  32'(ack1), 32'(a.port));
                chk("ack_cycle", cyc, a.cyc);
                chk("ack_err",   32'(ack1 ? err1 : err0), 32'(a.err));
                chk("ack_rdata", ack1 ? rdata1 : rdata0, a.rdata);
            end
        end
        if (mem_read || mem_write) begin
            if (mq.size() == 0) chk("unexpected_mem", 32'({mem_write, mem_read}), 32'd0);
            else begin
                m = mq.pop_front();
                chk("mem_kind",  32'(mem_write), 32'(m.wr));
                chk("mem_addr",  mem_addr, m.addr);
                chk("mem_cycle", cyc, m.cyc);
                if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
            end
        end
        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            p = pq.pop_front();
            chk(p.name, sig_val(p.sig), p.val);
        end
        if (done || cyc > 3000) begin
            if (!done) chk("watchdog", cyc, 32'd0);
            chk("sb_left",       sbq.size(), 32'd0);
            chk("mem_exp_left",  mq.size(), 32'd0);
            chk("probe_left",    pq.size(), 32'd0);
            chk("grant_timeout", stim_to, 32'd0);
            chk("word12_kept",   mem[12], 32'hCAFE_000C);
            chk("word8_written", mem[8], 32'h1234_5678);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    task automatic probe(input int c, input int s, input logic [31:0] v, input string n);
        probe_t p;
        p.cyc = c; p.sig = s; p.val = v; p.name = n;
        pq.push_back(p);
    endtask

    // Single-port request held until granted; expectations are pushed at
    // the grant cycle T: memory access at T+1 (unless errored), ack at T+2.
    // Called and returns at posedge+1.
    task automatic issue(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic e, input logic [31:0] rd, output int gc);
        ack_exp_t ae;
        mem_exp_t me;
        int       n = 0;
        logic     g = 1'b0;
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        gc = -1;
        while (!g && n < 16) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) g = 1'b1;
            else begin n++; @(posedge clk); #1; end
        end
        if (!g) stim_to++;
        else begin
            gc = cyc;
            ae.cyc = cyc + 2; ae.port = p; ae.err = e; ae.rdata = rd;
            sbq.push_back(ae);
            if (!e) begin
                me.cyc = cyc + 1; me.wr = w; me.addr = a; me.wdata = d;
                mq.push_back(me);
            end
        end
        @(posedge clk); #1;
        if (p) begin req1 = 1'b0; we1 = 1'b0; end
        else   begin req0 = 1'b0; we0 = 1'b0; end
    endtask

    // Both ports request continuously from an idle, freshly reset pointer:
    // grants at T, T+2, ... alternate starting with port 0.
    task automatic contend(input int n);
        ack_exp_t ae;
        mem_exp_t me;
        int       t0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            ae.cyc = t0 + 2*k + 2; ae.port = k[0]; ae.err = 1'b0;
            ae.rdata = k[0] ? 32'h55AA_55AA : 32'hDEAD_BEEF;
            sbq.push_back(ae);
            me.cyc = t0 + 2*k + 1; me.wr = 1'b0; me.addr = k[0] ? 32'h14 : 32'h10; me.wdata = '0;
            mq.push_back(me);
        end
        probe(t0, S_GNT0, 32'd1, "contend_first_gnt0");
        probe(t0, S_GNT1, 32'd0, "contend_first_gnt1");
        repeat (2*n - 1) @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        int t;
        // Reset state, with a request pending that must not be granted.
        repeat (3) @(posedge clk);
        #1;
        req0 = 1'b1; addr0 = 32'h10;
        probe(cyc, S_GNT0,  32'd0, "rst_gnt0");
        probe(cyc, S_ACK0,  32'd0, "rst_ack0");
        probe(cyc, S_ACK1,  32'd0, "rst_ack1");
        probe(cyc, S_ERR0,  32'd0, "rst_err0");
        probe(cyc, S_ERR1,  32'd0, "rst_err1");
        probe(cyc, S_RD0,   32'd0, "rst_rdata0");
        probe(cyc, S_RD1,   32'd0, "rst_rdata1");
        probe(cyc, S_BUSY,  32'd0, "rst_busy");
        probe(cyc, S_MADDR, 32'd0, "rst_mem_addr");
        probe(cyc, S_MRD,   32'd0, "rst_mem_read");
        @(posedge clk); #1;
        req0 = 1'b0; reset = 1'b1;
        @(posedge clk); #1;

        // Single read, then a loader write while rdata0 must hold.
        issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, t);
        probe(t + 1, S_BUSY, 32'd1, "busy_in_access");
        issue(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0, t);
        probe(t + 2, S_RD0, 32'hDEAD_BEEF, "rdata0_hold");
        issue(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1234_5678, t);

        // Errors and the upper address boundary.
        issue(1'b0, 1'b0, 32'h11,  32'h0, 1'b1, 32'h0, t);
        issue(1'b0, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, t);
        issue(1'b1, 1'b1, 32'h402, 32'hFFFF_FFFF, 1'b1, 32'h0, t);
        issue(1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hA500_00FF, t);
        repeat (3) @(posedge clk);
        #1;

        // Reset dropped during ACCESS of a loader write.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h7777_7777;
        @(negedge clk);
        if (!gnt1) stim_to++;
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0; reset = 1'b0;
        probe(cyc,     S_MWR,  32'd0, "abort_mem_write");
        probe(cyc + 1, S_ACK1, 32'd0, "abort_no_ack1");
        probe(cyc + 1, S_BUSY, 32'd0, "abort_idle");
        @(posedge clk); #1;
        reset = 1'b1;

        // Sustained contention: 0,1,0,1 with one ack every two cycles.
        contend(4);
        @(posedge clk); #1;

        // Leave port 0 as last winner, reset while idle, then the first
        // contention must still go to port 0.
        issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, t);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        contend(2);

        repeat (4) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
